// File: rtl/axilite_slave_test_pkg.sv
// Shared AXI-lite response codes plus LFSR helpers for the AXI-lite write-sequence checker.
package axilite_slave_test_pkg;

    localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0]  AXI_RESP_SLVERR = 2'b10;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    // Fibonacci form of x^16 + x^14 + x^13 + x^11 + 1, shifting right.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

endpackage

// File: rtl/axilite_test_lfsr.sv
// Free-running 16-bit LFSR used to throttle the checker's AW/W readies.
module axilite_test_lfsr
    import axilite_slave_test_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] lfsr_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    assign lfsr_d = lfsr_next(lfsr_q);
    assign lfsr_o = lfsr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/axilite_slave_test.sv
// AXI-lite slave that checks writes arrive as an incrementing addr/data sequence and counts errors.
// Define AXILITE_SLAVE_TEST_BP_EN to throttle AW/W readies with a pseudo-random LFSR.
module axilite_slave_test
    import axilite_slave_test_pkg::*;
#(
    parameter int                            AXILITE_ADDR_WIDTH = 48,
    parameter int                            AXILITE_DATA_WIDTH = 64,
    parameter logic [AXILITE_ADDR_WIDTH-1:0] START_ADDR         = 48'h0000_2000_0000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [AXILITE_ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    input  logic [AXILITE_DATA_WIDTH-1:0] s_axi_wdata,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    output logic [1:0]                    s_axi_bresp,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    input  logic [AXILITE_ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    output logic [AXILITE_DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready,
    output logic [31:0]                   txn_count,
    output logic [15:0]                   err_count,
    output logic                          err_flag
);

    localparam int AW = AXILITE_ADDR_WIDTH;
    localparam int DW = AXILITE_DATA_WIDTH;

    logic          aw_held_q, aw_held_d;
    logic [AW-1:0] aw_addr_q, aw_addr_d;
    logic          w_held_q, w_held_d;
    logic [DW-1:0] w_data_q, w_data_d;
    logic          bvalid_q, bvalid_d;
    logic [1:0]    bresp_q, bresp_d;
    logic          rvalid_q, rvalid_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [31:0]   txn_count_q, txn_count_d;
    logic [15:0]   err_count_q, err_count_d;
    logic          err_flag_q, err_flag_d;
    logic [AW-1:0] exp_addr_q, exp_addr_d;
    logic [DW-1:0] exp_data_q, exp_data_d;
    logic [DW-1:0] last_wdata_q, last_wdata_d;

    logic aw_gate, w_gate;
    logic commit, mismatch;
    logic aw_hs, w_hs, ar_hs;

`ifdef AXILITE_SLAVE_TEST_BP_EN
    logic [15:0] lfsr;
    logic [13:0] lfsr_unused;

    axilite_test_lfsr u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .lfsr_o (lfsr)
    );

    assign aw_gate     = lfsr[0];
    assign w_gate      = lfsr[1];
    assign lfsr_unused = lfsr[15:2];
`else
    assign aw_gate = 1'b1;
    assign w_gate  = 1'b1;
`endif

    // Reads return the last committed data regardless of address.
    logic araddr_unused;
    assign araddr_unused = ^s_axi_araddr;

    assign commit   = aw_held_q && w_held_q && (!bvalid_q || s_axi_bready);
    assign mismatch = (aw_addr_q != exp_addr_q) || (w_data_q != exp_data_q);

    // A held entry frees its slot in the same cycle it commits, sustaining one pair per cycle.
    assign s_axi_awready = !rst && aw_gate && (!aw_held_q || commit);
    assign s_axi_wready  = !rst && w_gate && (!w_held_q || commit);
    assign s_axi_arready = !rst && !rvalid_q;

    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_hs  = s_axi_wvalid && s_axi_wready;
    assign ar_hs = s_axi_arvalid && s_axi_arready;

    assign s_axi_bvalid = bvalid_q;
    assign s_axi_bresp  = bresp_q;
    assign s_axi_rvalid = rvalid_q;
    assign s_axi_rdata  = rdata_q;
    assign s_axi_rresp  = AXI_RESP_OKAY;
    assign txn_count    = txn_count_q;
    assign err_count    = err_count_q;
    assign err_flag     = err_flag_q;

    always_comb begin
        aw_held_d    = aw_held_q;
        aw_addr_d    = aw_addr_q;
        w_held_d     = w_held_q;
        w_data_d     = w_data_q;
        bvalid_d     = bvalid_q;
        bresp_d      = bresp_q;
        rvalid_d     = rvalid_q;
        rdata_d      = rdata_q;
        txn_count_d  = txn_count_q;
        err_count_d  = err_count_q;
        err_flag_d   = err_flag_q;
        exp_addr_d   = exp_addr_q;
        exp_data_d   = exp_data_q;
        last_wdata_d = last_wdata_q;

        if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_addr_d = s_axi_awaddr;
        end else if (commit) begin
            aw_held_d = 1'b0;
        end

        if (w_hs) begin
            w_held_d = 1'b1;
            w_data_d = s_axi_wdata;
        end else if (commit) begin
            w_held_d = 1'b0;
        end

        if (commit) begin
            bvalid_d     = 1'b1;
            bresp_d      = mismatch ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            txn_count_d  = txn_count_q + 32'd1;
            exp_addr_d   = exp_addr_q + AW'(1);
            exp_data_d   = exp_data_q + DW'(1);
            last_wdata_d = w_data_q;
            if (mismatch) begin
                err_flag_d = 1'b1;
                if (err_count_q != 16'hFFFF) begin
                    err_count_d = err_count_q + 16'd1;
                end
            end
        end else if (s_axi_bready) begin
            bvalid_d = 1'b0;
        end

        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = last_wdata_q;
        end else if (s_axi_rready) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_held_q    <= 1'b0;
            aw_addr_q    <= '0;
            w_held_q     <= 1'b0;
            w_data_q     <= '0;
            bvalid_q     <= 1'b0;
            bresp_q      <= AXI_RESP_OKAY;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            txn_count_q  <= '0;
            err_count_q  <= '0;
            err_flag_q   <= 1'b0;
            exp_addr_q   <= START_ADDR;
            exp_data_q   <= '0;
            last_wdata_q <= '0;
        end else begin
            aw_held_q    <= aw_held_d;
            aw_addr_q    <= aw_addr_d;
            w_held_q     <= w_held_d;
            w_data_q     <= w_data_d;
            bvalid_q     <= bvalid_d;
            bresp_q      <= bresp_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            txn_count_q  <= txn_count_d;
            err_count_q  <= err_count_d;
            err_flag_q   <= err_flag_d;
            exp_addr_q   <= exp_addr_d;
            exp_data_q   <= exp_data_d;
            last_wdata_q <= last_wdata_d;
        end
    end

endmodule

// File: tb/tb_axilite_slave_test.sv
// Directed plus randomized bench for axilite_slave_test, scored against a sequence-count model.
module tb_axilite_slave_test;

    localparam logic [47:0] START = 48'h0000_2000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [47:0] s_axi_awaddr;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [63:0] s_axi_wdata;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [47:0] s_axi_araddr;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [63:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic [31:0] txn_count;
    logic [15:0] err_count;
    logic        err_flag;

    axilite_slave_test dut (
        .clk           (clk),
        .rst           (rst),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .txn_count     (txn_count),
        .err_count     (err_count),
        .err_flag      (err_flag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Reference model: the n-th pair after reset must carry START+n / n.
    int unsigned m_n;
    logic [15:0] m_err;
    logic        m_flag;
    logic [63:0] m_last;
    logic [1:0]  exp_q[$];

    logic [1:0]  obs_q[$];
    int          obs_cyc[$];
    bit          rdone;

    always @(negedge clk) begin
        if (!rst && s_axi_bvalid && s_axi_bready) begin
            obs_q.push_back(s_axi_bresp);
            obs_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_n    = 0;
        m_err  = 16'd0;
        m_flag = 1'b0;
        m_last = 64'd0;
        exp_q.delete();
        obs_q.delete();
        obs_cyc.delete();
    endfunction

    function automatic void model_pair(input logic [47:0] a, input logic [63:0] d);
        bit bad;
        bad = (a !== START + 48'(m_n)) || (d !== 64'(m_n));
        exp_q.push_back(bad ? 2'b10 : 2'b00);
        m_n++;
        if (bad) begin
            m_flag = 1'b1;
            if (m_err != 16'hFFFF) m_err++;
        end
        m_last = d;
    endfunction

    task automatic send_aw(input logic [47:0] a, input int dly);
        bit hs = 0;
        int n  = 0;
        repeat (dly) begin @(posedge clk); #1; end
        s_axi_awaddr  = a;
        s_axi_awvalid = 1'b1;
        while (!hs && n < 100) begin
            @(negedge clk);
            hs = s_axi_awready;
            @(posedge clk); #1;
            n++;
        end
        s_axi_awvalid = 1'b0;
        check("aw_handshake", 64'(hs), 64'd1);
    endtask

    task automatic send_w(input logic [63:0] d, input int dly);
        bit hs = 0;
        int n  = 0;
        repeat (dly) begin @(posedge clk); #1; end
        s_axi_wdata  = d;
        s_axi_wvalid = 1'b1;
        while (!hs && n < 100) begin
            @(negedge clk);
            hs = s_axi_wready;
            @(posedge clk); #1;
            n++;
        end
        s_axi_wvalid = 1'b0;
        check("w_handshake", 64'(hs), 64'd1);
    endtask

    task automatic send_pair(input logic [47:0] a, input logic [63:0] d, input int da, input int dw);
        model_pair(a, d);
        fork
            send_aw(a, da);
            send_w(d, dw);
        join
    endtask

    task automatic wait_drain();
        int n = 0;
        s_axi_bready = 1'b1;
        while (obs_q.size() < exp_q.size() && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic verify_and_clear(input string tag);
        check({tag, "_nresp"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check($sformatf("%s_bresp%0d", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
        check({tag, "_txn"}, 64'(txn_count), 64'(m_n));
        check({tag, "_err"}, 64'(err_count), 64'(m_err));
        check({tag, "_flag"}, 64'(err_flag), 64'(m_flag));
        check({tag, "_bvalid_idle"}, 64'(s_axi_bvalid), 64'd0);
        exp_q.delete();
        obs_q.delete();
        obs_cyc.delete();
    endtask

    task automatic do_read(input logic [63:0] exp, input string tag);
        bit hs = 0;
        int n  = 0;
        s_axi_rready  = 1'b1;
        s_axi_araddr  = 48'($urandom);
        s_axi_arvalid = 1'b1;
        while (!hs && n < 50) begin
            @(negedge clk);
            hs = s_axi_arready;
            @(posedge clk); #1;
            n++;
        end
        s_axi_arvalid = 1'b0;
        check({tag, "_ar_hs"}, 64'(hs), 64'd1);
        @(negedge clk);
        check({tag, "_rvalid"}, 64'(s_axi_rvalid), 64'd1);
        check({tag, "_rdata"}, s_axi_rdata, exp);
        check({tag, "_rresp"}, 64'(s_axi_rresp), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        s_axi_awaddr = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0;  s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b0;
        s_axi_araddr = '0; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b0;
        rdone = 1'b0;
        model_reset();

        // Reset state
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        check("rst_awready", 64'(s_axi_awready), 64'd0);
        check("rst_wready", 64'(s_axi_wready), 64'd0);
        check("rst_arready", 64'(s_axi_arready), 64'd0);
        check("rst_bvalid", 64'(s_axi_bvalid), 64'd0);
        check("rst_bresp", 64'(s_axi_bresp), 64'd0);
        check("rst_rvalid", 64'(s_axi_rvalid), 64'd0);
        check("rst_rdata", s_axi_rdata, 64'd0);
        check("rst_rresp", 64'(s_axi_rresp), 64'd0);
        check("rst_txn", 64'(txn_count), 64'd0);
        check("rst_err", 64'(err_count), 64'd0);
        check("rst_flag", 64'(err_flag), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Minimum latency: handshake cycle 0, bvalid cycle 2
        s_axi_bready = 1'b1;
        model_pair(START, 64'd0);
        s_axi_awaddr = START; s_axi_awvalid = 1'b1;
        s_axi_wdata = 64'd0;  s_axi_wvalid = 1'b1;
        @(negedge clk);
        check("lat_c0_awready", 64'(s_axi_awready), 64'd1);
        check("lat_c0_wready", 64'(s_axi_wready), 64'd1);
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        @(negedge clk);
        check("lat_c1_bvalid", 64'(s_axi_bvalid), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("lat_c2_bvalid", 64'(s_axi_bvalid), 64'd1);
        check("lat_c2_bresp", 64'(s_axi_bresp), 64'd0);
        check("lat_c2_txn", 64'(txn_count), 64'd1);
        check("lat_c2_err", 64'(err_count), 64'd0);
        wait_drain();
        verify_and_clear("first");

        // Eight back-to-back pairs
        for (int i = 0; i < 8; i++)
            send_pair(START + 48'(m_n), 64'(m_n), 0, 0);
        wait_drain();
        check("b2b_count", 64'(obs_cyc.size()), 64'd8);
        if (obs_cyc.size() == 8)
            check("b2b_consecutive", 64'(obs_cyc[7] - obs_cyc[0]), 64'd7);
        verify_and_clear("b2b");

        // AW three cycles ahead of W
        fork
            send_pair(START + 48'(m_n), 64'(m_n), 0, 3);
            begin
                @(posedge clk); #1;
                @(negedge clk);
                check("awlead_awready1", 64'(s_axi_awready), 64'd0);
                @(negedge clk);
                check("awlead_awready2", 64'(s_axi_awready), 64'd0);
            end
        join
        wait_drain();
        verify_and_clear("awlead");

        // Data mismatch, then recovery on the following index
        send_pair(START + 48'(m_n), 64'(m_n) + 64'd4, 0, 0);
        send_pair(START + 48'(m_n), 64'(m_n), 0, 0);
        wait_drain();
        check("mis_err_count", 64'(err_count), 64'd1);
        check("mis_err_flag", 64'(err_flag), 64'd1);
        verify_and_clear("mismatch");

        // B backpressure with both channels still valid
        s_axi_bready = 1'b0;
        send_pair(START + 48'(m_n), 64'(m_n), 0, 0);
        send_pair(START + 48'(m_n), 64'(m_n), 0, 0);
        fork
            send_pair(START + 48'(m_n), 64'(m_n), 0, 0);
            begin
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    check($sformatf("bp_bvalid%0d", k), 64'(s_axi_bvalid), 64'd1);
                    check($sformatf("bp_bresp%0d", k), 64'(s_axi_bresp), 64'd0);
                    check($sformatf("bp_awready%0d", k), 64'(s_axi_awready), 64'd0);
                    check($sformatf("bp_wready%0d", k), 64'(s_axi_wready), 64'd0);
                end
                @(posedge clk); #1;
                s_axi_bready = 1'b1;
            end
        join
        wait_drain();
        verify_and_clear("bpress");

        // Readback of last committed data, held until rready
        send_pair(START + 48'(m_n), 64'h55, 0, 0);
        wait_drain();
        verify_and_clear("pre_read");
        s_axi_rready  = 1'b0;
        s_axi_arvalid = 1'b1;
        s_axi_araddr  = START;
        @(negedge clk);
        check("rd_arready", 64'(s_axi_arready), 64'd1);
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        @(negedge clk);
        check("rd_rvalid", 64'(s_axi_rvalid), 64'd1);
        check("rd_rdata", s_axi_rdata, 64'h55);
        check("rd_arready_busy", 64'(s_axi_arready), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rd_hold_rvalid", 64'(s_axi_rvalid), 64'd1);
        check("rd_hold_rdata", s_axi_rdata, 64'h55);

        // Reset while R and B are pending and an AW is held
        @(posedge clk); #1;
        s_axi_bready = 1'b0;
        fork
            send_aw(START + 48'(m_n), 0);
            send_w(64'(m_n), 0);
        join
        send_aw(START + 48'(m_n) + 48'd1, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("mrst_bvalid", 64'(s_axi_bvalid), 64'd0);
        check("mrst_rvalid", 64'(s_axi_rvalid), 64'd0);
        check("mrst_rdata", s_axi_rdata, 64'd0);
        check("mrst_txn", 64'(txn_count), 64'd0);
        check("mrst_err", 64'(err_count), 64'd0);
        check("mrst_flag", 64'(err_flag), 64'd0);
        check("mrst_awready", 64'(s_axi_awready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        s_axi_bready = 1'b1;
        do_read(64'd0, "post_rst_read");
        send_pair(START, 64'd0, 0, 0);
        wait_drain();
        verify_and_clear("post_rst");

        // Randomized delays, corruption and B backpressure
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    logic [47:0] a;
                    logic [63:0] d;
                    a = START + 48'(m_n);
                    d = 64'(m_n);
                    if ($urandom_range(0, 3) == 0) begin
                        if ($urandom_range(0, 1) == 1) a = a ^ (48'd1 << $urandom_range(0, 47));
                        else                           d = d ^ (64'd1 << $urandom_range(0, 63));
                    end
                    send_pair(a, d, $urandom_range(0, 3), $urandom_range(0, 3));
                end
                rdone = 1'b1;
            end
            begin
                while (!rdone) begin
                    @(posedge clk); #1;
                    s_axi_bready = 1'($urandom_range(0, 1));
                end
            end
        join
        wait_drain();
        verify_and_clear("random");
        do_read(m_last, "random_read");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
